// File: rtl/uart_tx_axis.sv
// uart_tx_axis: byte-stream UART transmitter.
// Accepts bytes over a ready/valid sink into a one-byte holding register and
// serialises them 8N1, LSB first, on tx_serial_o. Because the holding register
// can be refilled while a frame shifts out, consecutive frames run back to back.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (even or odd
// per OddParity) between the data bits and the stop bit, giving 11-bit frames.
module uart_tx_axis #(
  parameter int ClksPerBit = 104,
  parameter int OddParity  = 0
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_serial_o,
  output logic       busy_o
);

  localparam int CW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CW-1:0] BaudLast = CW'(ClksPerBit - 1);

  if (ClksPerBit < 2 || ClksPerBit > 65535 || OddParity < 0 || OddParity > 1) begin : g_param_check
    $error("uart_tx_axis: ClksPerBit must be 2..65535 and OddParity 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_data_q;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;
  logic            load;
  logic            accept;

`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;

  // Parity of a byte, folded with the configured sense.
  function automatic logic frame_parity(input logic [7:0] b);
    return (^b) ^ (OddParity != 0);
  endfunction
`endif

  assign bit_end = (baud_q == BaudLast);
  assign accept  = valid_i & ~hold_full_q;
  // The holding byte moves into the shifter from IDLE, or straight out of the
  // last stop cycle so the next start bit follows with no idle gap.
  assign load    = hold_full_q & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  // State register; reset puts the shifter back to IDLE mid-frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (hold_full_q) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
`else
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:   if (bit_end) state_d = hold_full_q ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Baud/bit counters, holding flag and shifter next values.
  always_comb begin
    baud_d      = '0;
    bit_idx_d   = 3'd0;
    hold_full_d = accept | (hold_full_q & ~load);
    shift_d     = shift_q;
    if (state_q != S_IDLE && !bit_end) begin
      baud_d = baud_q + CW'(1);
    end
    if (state_q == S_DATA) begin
      bit_idx_d = bit_end ? bit_idx_q + 3'd1 : bit_idx_q;
      if (bit_end) begin
        shift_d = shift_q >> 1;
      end
    end
    if (load) begin
      shift_d = hold_data_q;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured when the byte enters the shifter, before it shifts away.
  always_comb begin
    par_d = load ? frame_parity(hold_data_q) : par_q;
  end
`endif

  // Output logic: the serial level is decoded from the next state so the
  // registered line changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_o = ~hold_full_q;
    busy_o  = (state_q != S_IDLE) | hold_full_q;
  end

  // Control registers: counters, holding flag and the glitch-free line flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  // Data registers: holding byte and shifter contents are qualified by the
  // control state, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold_data_q <= data_i;
    end
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx_serial_o = tx_q;

endmodule
